game_input_ctrl: RTL and testbench

Front-end move-request controller for the 2048 game. Conditions four raw direction buttons and turns each accepted press into a one-hot `direction` plus an `enable` window for the game-logic FSM. Tracks the FSM's `wl` status to know when a move has been processed and when the game is over. Sits between the board's push-buttons and the game-logic block: it produces what game logic consumes, and consumes game logic's `wl` result.

---
 rtl/game_input_ctrl.sv | 135 +++++++++++++
 tb/tb_game_input_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_input_ctrl.sv
// Button conditioner and move-request FSM for the 2048 game logic; optional hold-to-repeat
// enabled by defining GAME_INPUT_REPEAT_EN.
module game_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_BUSY        = 4,
   parameter int TIMEOUT         = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   input  logic [1:0] wl,
   output logic [3:0] direction,
   output logic       enable,
   output logic [1:0] game_over,
   output logic       timeout_err
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BW = $clog2(MIN_BUSY + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OVER} state_t;

   state_t          state;
   logic [3:0]      sync1, sync2, deb, deb_d, press;
   logic [CW-1:0]   cnt [4];
   logic [BW-1:0]   busy_cnt;
   logic [TW-1:0]   tcnt;
   logic            single_press;

   assign single_press = (press != 4'b0) && ((press & (press - 4'd1)) == 4'b0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         press <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         deb_d <= deb;
         press <= deb & ~deb_d;
         // Level flips on the cycle the stability count reaches DEBOUNCE_CYCLES.
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef GAME_INPUT_REPEAT_EN
   logic [11:0] rpt_cnt;
   logic [3:0]  rpt_btn;
   logic        deb_single, rpt_fire;

   assign deb_single = (deb != 4'b0) && ((deb & (deb - 4'd1)) == 4'b0);
   assign rpt_fire   = (state == IDLE) && deb_single && (deb == rpt_btn) && (rpt_cnt == 12'hFFF);

   always_ff @(posedge clk) begin
      if (rst || state != IDLE || !deb_single || deb != rpt_btn) begin
         rpt_cnt <= '0;
         rpt_btn <= rst ? 4'b0 : deb;
      end else begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         direction   <= '0;
         enable      <= 1'b0;
         game_over   <= 2'b00;
         timeout_err <= 1'b0;
         busy_cnt    <= '0;
         tcnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (single_press) begin
                  direction <= press;
                  enable    <= 1'b1;
                  busy_cnt  <= '0;
                  state     <= ISSUE;
               end
`ifdef GAME_INPUT_REPEAT_EN
               else if (rpt_fire) begin
                  direction <= deb;
                  enable    <= 1'b1;
                  busy_cnt  <= '0;
                  state     <= ISSUE;
               end
`endif
            end
            ISSUE: begin
               if (busy_cnt == BW'(MIN_BUSY - 1)) begin
                  tcnt  <= '0;
                  state <= WAIT;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
            end
            WAIT: begin
               // A real result wins over a timeout landing in the same cycle.
               if (wl == 2'b00) begin
                  enable <= 1'b0;
                  state  <= IDLE;
               end else if (wl != 2'b11) begin
                  game_over <= wl;
                  enable    <= 1'b0;
                  state     <= OVER;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  enable      <= 1'b0;
                  state       <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: enable <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Randomized scoreboard bench for game_input_ctrl: stimulus queues expected moves, a monitor checks them.
module tb_game_input_ctrl;
   localparam int D  = 16;
   localparam int MB = 4;
   localparam int TO = 1024;
   localparam int STUCK = 1 << 30;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic [1:0] wl;
   logic [3:0] direction;
   logic       enable;
   logic [1:0] game_over;
   logic       timeout_err;

   always #5 clk = ~clk;

   game_input_ctrl #(.DEBOUNCE_CYCLES(D), .MIN_BUSY(MB), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .btn(btn), .wl(wl),
      .direction(direction), .enable(enable), .game_over(game_over), .timeout_err(timeout_err)
   );

   typedef struct {logic [3:0] dir; int len; logic [1:0] go; logic te;} exp_t;
   typedef struct {int k; logic [1:0] res;} plan_t;

   exp_t  exp_q[$];
   plan_t plan_q[$];
   int checks = 0, failures = 0, moves_seen = 0, moves_exp = 0;
   logic [1:0] go_model = 2'b00;
   logic       te_model = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model of one move: enable spans the busy issue window, then lasts until wl settles or times out.
   task automatic push_move(input int b, input int k, input logic [1:0] res);
      exp_t  e;
      plan_t p;
      e.dir = 4'b0001 << b;
      if (res == 2'b11) begin
         e.len = MB + TO;
         te_model = 1'b1;
      end else begin
         e.len = ((k > MB) ? k : MB) + 1;
         if (res != 2'b00) go_model = res;
      end
      e.go = go_model;
      e.te = te_model;
      p.k = k;
      p.res = res;
      exp_q.push_back(e);
      plan_q.push_back(p);
      moves_exp++;
   endtask

   task automatic wait_idle();
      int quiet = 0;
      for (int n = 0; n < 6000 && quiet < 40; n++) begin
         tick();
         quiet = (enable === 1'b1) ? 0 : quiet + 1;
      end
      if (quiet < 40) check("idle_wait_expired", quiet, 40);
   endtask

   task automatic do_move(input int b, input int k, input logic [1:0] res);
      push_move(b, k, res);
      btn = 4'b0001 << b;
      repeat (30) tick();
      btn = 4'b0000;
      wait_idle();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_direction"}, direction, 0);
      check({tag, "_enable"}, enable, 0);
      check({tag, "_game_over"}, game_over, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   // Game-logic responder: busy for k cycles of each enable window, then returns its result.
   initial begin
      plan_t p;
      bit    active;
      int    i;
      active = 0;
      i = 0;
      p.k = 0;
      p.res = 2'b00;
      wl = 2'b11;
      forever begin
         tick();
         if (enable === 1'b1) begin
            if (!active) begin
               active = 1;
               i = 0;
               if (plan_q.size() > 0) p = plan_q.pop_front();
               else begin
                  p.k = 0;
                  p.res = 2'b00;
               end
            end else begin
               i++;
            end
            wl = (i < p.k) ? 2'b11 : p.res;
         end else begin
            active = 0;
            wl = 2'b11;
         end
      end
   end

   // Monitor: every enable window must match the next expected move.
   initial begin
      exp_t cur;
      bit   prev, have, stable;
      int   cnt;
      prev = 0;
      have = 0;
      stable = 1;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (enable === 1'b1 && !prev) begin
            moves_seen++;
            cnt = 1;
            stable = 1;
            if (exp_q.size() == 0) begin
               have = 0;
               checks++;
               failures++;
               $display("FAIL unexpected_move direction=%b expected no move", direction);
            end else begin
               cur = exp_q.pop_front();
               have = 1;
               check("direction", direction, cur.dir);
            end
         end else if (enable === 1'b1 && prev) begin
            cnt++;
            if (have && direction !== cur.dir) stable = 0;
         end else if (prev && have) begin
            if (cur.len != 0) check("enable_len", cnt, cur.len);
            check("dir_stable", stable, 1);
            check("game_over", game_over, cur.go);
            check("timeout_err", timeout_err, cur.te);
            have = 0;
         end
         prev = (enable === 1'b1);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int b, b2, len, n_rep, done;
      exp_t e;
      plan_t p;
      rst = 1'b1;
      btn = 4'b0000;
      repeat (3) tick();
      check_reset_state("reset");
      rst = 1'b0;

      for (int g = 0; g < 4; g++) begin
         b   = (g == 0) ? 0 : $urandom_range(3, 0);
         len = (g == 0) ? 3 : $urandom_range(D - 3, 1);
         btn[b] = 1'b1;
         repeat (len) tick();
         btn = 4'b0000;
         repeat (30) tick();
      end
      check("glitch_moves", moves_seen, 0);
      check("glitch_direction", direction, 0);

      do_move(3, 6, 2'b00);

      btn = 4'b0110;
      repeat (30) tick();
      btn = 4'b0000;
      wait_idle();
      check("multi_press_moves", moves_seen, moves_exp);
      do_move(1, 0, 2'b00);

      for (int r = 0; r < 8; r++)
         do_move($urandom_range(3, 0), $urandom_range(8, 0), 2'b00);

      b  = $urandom_range(3, 0);
      b2 = (b + 1) % 4;
      push_move(b, 40, 2'b00);
      btn = 4'b0001 << b;
      repeat (25) tick();
      btn = 4'b0001 << b2;
      repeat (60) tick();
      btn = 4'b0000;
      wait_idle();
      check("busy_press_moves", moves_seen, moves_exp);

      do_move(0, STUCK, 2'b11);
      do_move(2, 3, 2'b00);

      b = $urandom_range(3, 0);
      e.dir = 4'b0001 << b;
      e.len = 0;
      e.go = 2'b00;
      e.te = 1'b0;
      p.k = STUCK;
      p.res = 2'b11;
      exp_q.push_back(e);
      plan_q.push_back(p);
      moves_exp++;
      btn = 4'b0001 << b;
      for (int n = 0; n < 100 && enable !== 1'b1; n++) tick();
      check("abort_started", enable, 1);
      repeat (8) tick();
      btn = 4'b0000;
      rst = 1'b1;
      tick();
      check_reset_state("mid_wait_reset");
      rst = 1'b0;
      go_model = 2'b00;
      te_model = 1'b0;
      wait_idle();

`ifdef GAME_INPUT_REPEAT_EN
      n_rep = 1;
      done = D + 4 + MB + 1;
      while (done + 4096 + MB + 1 < 10000) begin
         n_rep++;
         done += 4096 + MB + 1;
      end
`else
      n_rep = 1;
      done = 0;
`endif
      for (int r = 0; r < n_rep; r++) push_move(2, 0, 2'b00);
      btn = 4'b0100;
      repeat (10000) tick();
      btn = 4'b0000;
      wait_idle();
      check("hold_moves", moves_seen, moves_exp);

      do_move(1, 2, 2'b10);
      btn = 4'b1000;
      repeat (40) tick();
      btn = 4'b0000;
      repeat (30) tick();
      check("over_moves", moves_seen, moves_exp);
      check("over_game_over", game_over, 2'b10);
      check("over_enable", enable, 0);

      rst = 1'b1;
      tick();
      check_reset_state("final_reset");
      rst = 1'b0;
      go_model = 2'b00;
      te_model = 1'b0;
      do_move($urandom_range(3, 0), $urandom_range(6, 0), 2'b01);

      check("queue_left", exp_q.size(), 0);
      check("moves_total", moves_seen, moves_exp);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
